// File: rtl/friscv_axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the cache ports and the memory port.
// master drives AR and accepts R; slave accepts AR and drives R.
interface friscv_axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int DATA_W = 128
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [2:0]        arprot;
    logic [ID_W-1:0]   arid;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arprot, arid, rready,
        input  arready, rvalid, rid, rresp, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arprot, arid, rready,
        output arready, rvalid, rid, rresp, rdata, rlast
    );
endinterface

// File: rtl/friscv_axi_rd_arbiter.sv
// Shares one AXI4 read channel between icache and dcache: round-robin AR arbitration,
// ID-mask tagging, R routing by RID, per-requester outstanding caps.
// Define FRISCV_RDARB_FIXED_PRIO_EN to make dcache always win ties instead of round-robin.
module friscv_axi_rd_arbiter #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 128,
    parameter int IC_ID_MASK = 'h10,
    parameter int DC_ID_MASK = 'h20,
    parameter int MAX_OSTDG  = 4
)(
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            srst,
    friscv_axi_rd_arbiter_if.slave          ic,
    friscv_axi_rd_arbiter_if.slave          dc,
    friscv_axi_rd_arbiter_if.master         mem,
    output logic                            unmapped_rid
);

    localparam int CNT_W = $clog2(MAX_OSTDG + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_OSTDG);
    localparam logic [AXI_ID_W-1:0] IC_MASK = AXI_ID_W'(IC_ID_MASK);
    localparam logic [AXI_ID_W-1:0] DC_MASK = AXI_ID_W'(DC_ID_MASK);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant_dc;
    logic               w_grant_nxt;
    logic [CNT_W-1:0]   r_ic_cnt;
    logic [CNT_W-1:0]   r_dc_cnt;
    logic               r_unmapped;
`ifndef FRISCV_RDARB_FIXED_PRIO_EN
    logic               r_last_dc;
`endif

    logic                  w_ic_elig;
    logic                  w_dc_elig;
    logic                  w_hs;
    logic [AXI_ADDR_W-1:0] w_araddr;
    logic [AXI_ID_W-1:0]   w_arid;
    logic                  w_ic_hit;
    logic                  w_dc_hit;
    logic [AXI_DATA_W-1:0] w_rdata;

    assign w_ic_elig = ic.arvalid && (r_ic_cnt < CNT_MAX);
    assign w_dc_elig = dc.arvalid && (r_dc_cnt < CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_dc;
        case (r_state)
            IDLE: begin
                if (w_ic_elig && w_dc_elig) begin
`ifdef FRISCV_RDARB_FIXED_PRIO_EN
                    w_grant_nxt = 1'b1;
`else
                    w_grant_nxt = !r_last_dc;
`endif
                    w_state_nxt = GRANT;
                end else if (w_ic_elig) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = GRANT;
                end else if (w_dc_elig) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ic.arready  = 1'b0;
        dc.arready  = 1'b0;
        mem.arvalid = 1'b0;
        w_araddr    = ic.araddr;
        w_arid      = ic.arid | IC_MASK;
        mem.arlen   = ic.arlen;
        mem.arsize  = ic.arsize;
        mem.arburst = ic.arburst;
        mem.arprot  = ic.arprot;
        if (r_grant_dc) begin
            w_araddr    = dc.araddr;
            w_arid      = dc.arid | DC_MASK;
            mem.arlen   = dc.arlen;
            mem.arsize  = dc.arsize;
            mem.arburst = dc.arburst;
            mem.arprot  = dc.arprot;
        end
        if (r_state == GRANT) begin
            if (r_grant_dc) begin
                mem.arvalid = dc.arvalid;
                dc.arready  = mem.arready;
            end else begin
                mem.arvalid = ic.arvalid;
                ic.arready  = mem.arready;
            end
        end
        w_hs = mem.arvalid && mem.arready;
    end

    assign mem.araddr = w_araddr;
    assign mem.arid   = w_arid;

    // icache mask takes precedence if a RID ever carries both masks
    assign w_ic_hit = |(mem.rid & IC_MASK);
    assign w_dc_hit = !w_ic_hit && |(mem.rid & DC_MASK);
    assign w_rdata  = mem.rdata;

    assign ic.rvalid = mem.rvalid && w_ic_hit;
    assign dc.rvalid = mem.rvalid && w_dc_hit;
    assign ic.rid    = mem.rid & ~IC_MASK;
    assign dc.rid    = mem.rid & ~DC_MASK;
    assign ic.rresp  = mem.rresp;
    assign dc.rresp  = mem.rresp;
    assign ic.rdata  = w_rdata;
    assign dc.rdata  = w_rdata;
    assign ic.rlast  = mem.rlast;
    assign dc.rlast  = mem.rlast;
    assign mem.rready = w_ic_hit ? ic.rready : (w_dc_hit ? dc.rready : 1'b1);
    assign unmapped_rid = r_unmapped;

    // Decrement saturates at zero so beats returning after a reset cannot wrap the count
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        if (inc && !dec)                     return cnt + 1'b1;
        else if (dec && !inc && cnt != '0)   return cnt - 1'b1;
        else                                 return cnt;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_grant_dc <= 1'b0;
            r_ic_cnt   <= '0;
            r_dc_cnt   <= '0;
            r_unmapped <= 1'b0;
`ifndef FRISCV_RDARB_FIXED_PRIO_EN
            r_last_dc  <= 1'b1;
`endif
        end else if (srst) begin
            r_state    <= IDLE;
            r_grant_dc <= 1'b0;
            r_ic_cnt   <= '0;
            r_dc_cnt   <= '0;
            r_unmapped <= 1'b0;
`ifndef FRISCV_RDARB_FIXED_PRIO_EN
            r_last_dc  <= 1'b1;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant_dc <= w_grant_nxt;
            r_ic_cnt   <= cnt_next(r_ic_cnt, w_hs && !r_grant_dc,
                                   ic.rvalid && ic.rready && mem.rlast);
            r_dc_cnt   <= cnt_next(r_dc_cnt, w_hs && r_grant_dc,
                                   dc.rvalid && dc.rready && mem.rlast);
            r_unmapped <= mem.rvalid && !w_ic_hit && !w_dc_hit;
`ifndef FRISCV_RDARB_FIXED_PRIO_EN
            if (w_hs) r_last_dc <= r_grant_dc;
`endif
        end
    end

endmodule

// File: tb/tb_friscv_axi_rd_arbiter.sv
// Scoreboard bench for friscv_axi_rd_arbiter: directed stimulus pushes expected AR/R
// transfers into queues; a negedge monitor pops and compares on every DUT handshake.
module tb_friscv_axi_rd_arbiter;

    logic aclk;
    logic aresetn;
    logic srst;
    logic unmapped_rid;

    friscv_axi_rd_arbiter_if #(.ADDR_W(32), .ID_W(8), .DATA_W(128)) ic_if ();
    friscv_axi_rd_arbiter_if #(.ADDR_W(32), .ID_W(8), .DATA_W(128)) dc_if ();
    friscv_axi_rd_arbiter_if #(.ADDR_W(32), .ID_W(8), .DATA_W(128)) mem_if ();

    friscv_axi_rd_arbiter #(
        .AXI_ADDR_W (32),
        .AXI_ID_W   (8),
        .AXI_DATA_W (128),
        .IC_ID_MASK ('h10),
        .DC_ID_MASK ('h20),
        .MAX_OSTDG  (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .srst         (srst),
        .ic           (ic_if),
        .dc           (dc_if),
        .mem          (mem_if),
        .unmapped_rid (unmapped_rid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] addr; logic [7:0] id; } ar_t;
    typedef struct { logic [7:0] id; logic [127:0] data; } r_t;

    ar_t exp_ar[$];
    r_t  exp_ic[$];
    r_t  exp_dc[$];
    ar_t m_ar;
    r_t  m_r;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_unm_seen = 0;
    int  n_unm_exp  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
    endtask

    function automatic void push_ar(input logic [31:0] a, input logic [7:0] id);
        ar_t e; e.addr = a; e.id = id; exp_ar.push_back(e);
    endfunction
    function automatic void push_ic(input logic [7:0] id, input logic [127:0] d);
        r_t e; e.id = id; e.data = d; exp_ic.push_back(e);
    endfunction
    function automatic void push_dc(input logic [7:0] id, input logic [127:0] d);
        r_t e; e.id = id; e.data = d; exp_dc.push_back(e);
    endfunction

    // Monitor: every handshake the DUT presents is matched against the scoreboard
    always @(negedge aclk) begin
        if (mem_if.arvalid && mem_if.arready) begin
            if (exp_ar.size() == 0) unexpected("mem_ar");
            else begin
                m_ar = exp_ar.pop_front();
                check("mem_araddr", mem_if.araddr, m_ar.addr);
                check("mem_arid", mem_if.arid, m_ar.id);
            end
        end
        if (ic_if.rvalid && ic_if.rready) begin
            if (exp_ic.size() == 0) unexpected("ic_r");
            else begin
                m_r = exp_ic.pop_front();
                check("ic_rid", ic_if.rid, m_r.id);
                check("ic_rdata", ic_if.rdata, m_r.data);
            end
        end
        if (dc_if.rvalid && dc_if.rready) begin
            if (exp_dc.size() == 0) unexpected("dc_r");
            else begin
                m_r = exp_dc.pop_front();
                check("dc_rid", dc_if.rid, m_r.id);
                check("dc_rdata", dc_if.rdata, m_r.data);
            end
        end
        if (unmapped_rid) n_unm_seen++;
    end

    task automatic issue_ar(input bit to_dc, input logic [31:0] a, input logic [7:0] id);
        bit ok = 1'b0;
        if (to_dc) begin dc_if.arvalid = 1'b1; dc_if.araddr = a; dc_if.arid = id; end
        else       begin ic_if.arvalid = 1'b1; ic_if.araddr = a; ic_if.arid = id; end
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (to_dc ? dc_if.arready : ic_if.arready) begin ok = 1'b1; break; end
        end
        check("ar_handshake_timeout", ok, 1'b1);
        @(posedge aclk); #1;
        if (to_dc) dc_if.arvalid = 1'b0; else ic_if.arvalid = 1'b0;
    endtask

    task automatic send_r(input logic [7:0] rid, input logic [127:0] d, input logic last);
        bit ok = 1'b0;
        mem_if.rvalid = 1'b1; mem_if.rid = rid; mem_if.rdata = d; mem_if.rlast = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (mem_if.rready) begin ok = 1'b1; break; end
        end
        check("r_handshake_timeout", ok, 1'b1);
        @(posedge aclk); #1;
        mem_if.rvalid = 1'b0; mem_if.rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hs;
        aresetn = 1'b0; srst = 1'b0;
        ic_if.arvalid = 0; ic_if.araddr = '0; ic_if.arlen = 8'd3; ic_if.arsize = 3'd4;
        ic_if.arburst = 2'd1; ic_if.arprot = 3'd0; ic_if.arid = '0; ic_if.rready = 1'b1;
        dc_if.arvalid = 0; dc_if.araddr = '0; dc_if.arlen = 8'd0; dc_if.arsize = 3'd4;
        dc_if.arburst = 2'd1; dc_if.arprot = 3'd1; dc_if.arid = '0; dc_if.rready = 1'b1;
        mem_if.arready = 1'b0; mem_if.rvalid = 1'b0; mem_if.rid = '0; mem_if.rresp = 2'd0;
        mem_if.rdata = '0; mem_if.rlast = 1'b0;

        // reset state
        repeat (2) @(negedge aclk);
        check("rst_mem_arvalid", mem_if.arvalid, 1'b0);
        check("rst_ic_arready", ic_if.arready, 1'b0);
        check("rst_dc_arready", dc_if.arready, 1'b0);
        check("rst_unmapped", unmapped_rid, 1'b0);
        @(posedge aclk); #1 aresetn = 1'b1; mem_if.arready = 1'b1;

        // icache single read: one-cycle AR latency, tagged ID, routed R
        @(posedge aclk); #1;
        ic_if.arvalid = 1'b1; ic_if.araddr = 32'h100; ic_if.arid = 8'h01;
        push_ar(32'h100, 8'h11);
        @(negedge aclk); check("lat_cycle0_arvalid", mem_if.arvalid, 1'b0);
        @(negedge aclk); check("lat_cycle1_arvalid", mem_if.arvalid, 1'b1);
        check("lat_ic_arready", ic_if.arready, 1'b1);
        check("lat_mem_arlen", mem_if.arlen, 8'd3);
        @(posedge aclk); #1 ic_if.arvalid = 1'b0;
        push_ic(8'h01, 128'hD1);
        send_r(8'h11, 128'hD1, 1'b1);

        // arbitration with both requesters held
        @(posedge aclk); #1 srst = 1'b1;
        @(posedge aclk); #1 srst = 1'b0;
        check("srst_mem_arvalid", mem_if.arvalid, 1'b0);
`ifdef FRISCV_RDARB_FIXED_PRIO_EN
        repeat (4) push_ar(32'h300, 8'h23);
`else
        repeat (2) begin push_ar(32'h200, 8'h12); push_ar(32'h300, 8'h23); end
`endif
        ic_if.arvalid = 1'b1; ic_if.araddr = 32'h200; ic_if.arid = 8'h02;
        dc_if.arvalid = 1'b1; dc_if.araddr = 32'h300; dc_if.arid = 8'h03;
        hs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (mem_if.arvalid && mem_if.arready) hs++;
            if (hs == 4) break;
        end
        check("arb_grant_count", hs, 4);
        @(posedge aclk); #1 ic_if.arvalid = 1'b0; dc_if.arvalid = 1'b0;
`ifdef FRISCV_RDARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin push_dc(8'h03, 128'hA0 + i); send_r(8'h23, 128'hA0 + i, 1'b1); end
`else
        for (int i = 0; i < 2; i++) begin push_ic(8'h02, 128'hB0 + i); send_r(8'h12, 128'hB0 + i, 1'b1); end
        for (int i = 0; i < 2; i++) begin push_dc(8'h03, 128'hC0 + i); send_r(8'h23, 128'hC0 + i, 1'b1); end
`endif

        // outstanding cap on icache; dcache still served
        for (int i = 0; i < 4; i++) begin push_ar(32'h400, 8'h14); issue_ar(1'b0, 32'h400, 8'h04); end
        ic_if.arvalid = 1'b1; ic_if.araddr = 32'h500; ic_if.arid = 8'h05;
        repeat (5) @(negedge aclk);
        check("cap_ic_arready", ic_if.arready, 1'b0);
        check("cap_mem_arvalid", mem_if.arvalid, 1'b0);
        @(posedge aclk); #1;
        push_ar(32'h600, 8'h26);
        issue_ar(1'b1, 32'h600, 8'h06);
        repeat (3) @(negedge aclk);
        check("cap_ic_arready_after_dc", ic_if.arready, 1'b0);
        @(posedge aclk); #1;
        push_ic(8'h04, 128'hD4);
        send_r(8'h14, 128'hD4, 1'b1);
        push_ar(32'h500, 8'h15);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (ic_if.arready) begin ok = 1'b1; break; end
        end
        check("cap_release_grant", ok, 1'b1);
        @(posedge aclk); #1 ic_if.arvalid = 1'b0;

        // interleaved R with dcache back-pressure
        dc_if.rready = 1'b0;
        mem_if.rvalid = 1'b1; mem_if.rid = 8'h21; mem_if.rdata = 128'hD5; mem_if.rlast = 1'b0;
        @(negedge aclk);
        check("intlv_mem_rready_dc", mem_if.rready, 1'b0);
        check("intlv_dc_rvalid", dc_if.rvalid, 1'b1);
        check("intlv_ic_rvalid_off", ic_if.rvalid, 1'b0);
        @(posedge aclk); #1;
        push_ic(8'h02, 128'hD6);
        mem_if.rid = 8'h12; mem_if.rdata = 128'hD6;
        @(negedge aclk);
        check("intlv_dc_rvalid_off", dc_if.rvalid, 1'b0);
        check("intlv_mem_rready_ic", mem_if.rready, 1'b1);
        @(posedge aclk); #1 mem_if.rvalid = 1'b0; dc_if.rready = 1'b1;
        push_dc(8'h01, 128'hD5);
        send_r(8'h21, 128'hD5, 1'b0);

        // unmapped RID is drained and flagged for one cycle
        ic_if.rready = 1'b0; dc_if.rready = 1'b0;
        mem_if.rvalid = 1'b1; mem_if.rid = 8'h03; mem_if.rdata = 128'hD7; mem_if.rlast = 1'b1;
        n_unm_exp++;
        @(negedge aclk);
        check("unm_mem_rready", mem_if.rready, 1'b1);
        check("unm_ic_rvalid", ic_if.rvalid, 1'b0);
        check("unm_dc_rvalid", dc_if.rvalid, 1'b0);
        check("unm_flag_before", unmapped_rid, 1'b0);
        @(posedge aclk); #1 mem_if.rvalid = 1'b0; mem_if.rlast = 1'b0;
        ic_if.rready = 1'b1; dc_if.rready = 1'b1;
        @(negedge aclk); check("unm_flag_pulse", unmapped_rid, 1'b1);
        @(negedge aclk); check("unm_flag_clear", unmapped_rid, 1'b0);

        // async reset while GRANT is pending with two reads outstanding
        @(posedge aclk); #1 aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin push_ar(32'h700, 8'h17); issue_ar(1'b0, 32'h700, 8'h07); end
        mem_if.arready = 1'b0;
        ic_if.arvalid = 1'b1; ic_if.araddr = 32'h800; ic_if.arid = 8'h08;
        repeat (2) @(negedge aclk);
        check("rst_pending_arvalid", mem_if.arvalid, 1'b1);
        #1 aresetn = 1'b0;
        #1;
        check("rst_async_arvalid", mem_if.arvalid, 1'b0);
        check("rst_async_ic_arready", ic_if.arready, 1'b0);
        @(posedge aclk); #1 ic_if.arvalid = 1'b0; mem_if.arready = 1'b1; aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin push_ic(8'h07, 128'hE0 + i); send_r(8'h17, 128'hE0 + i, 1'b1); end
        // counter must be exactly zero: four grants fit, a fifth is held off
        for (int i = 0; i < 4; i++) begin push_ar(32'h900, 8'h19); issue_ar(1'b0, 32'h900, 8'h09); end
        ic_if.arvalid = 1'b1; ic_if.araddr = 32'hA00; ic_if.arid = 8'h0A;
        repeat (5) @(negedge aclk);
        check("post_rst_cap_arvalid", mem_if.arvalid, 1'b0);
        @(posedge aclk); #1 ic_if.arvalid = 1'b0;

        repeat (3) @(negedge aclk);
        check("left_exp_ar", exp_ar.size(), 0);
        check("left_exp_ic", exp_ic.size(), 0);
        check("left_exp_dc", exp_dc.size(), 0);
        check("unmapped_pulse_count", n_unm_seen, n_unm_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
